// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 controller: opcodes, state encodings, instruction classes.
// Optional build macro SAP1_CTRL_VAR_LEN_EN shortens instructions whose tail cycles do nothing.
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_T6   = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    // Opcode already classified, so the sequencer stays independent of opcode width.
    typedef enum logic [2:0] {
        INS_LDA = 3'd0,
        INS_ADD = 3'd1,
        INS_SUB = 3'd2,
        INS_OUT = 3'd3,
        INS_HLT = 3'd4,
        INS_NOP = 3'd5
    } instr_t;

endpackage

// File: rtl/sap1_ring_counter.sv
// T-state sequencer for the SAP-1 controller: state register plus next-state logic.
// With SAP1_CTRL_VAR_LEN_EN defined, LDA ends after T5 and OUT/NOP end after T4.
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_run,
    input  instr_t i_instr,
    output state_t o_state
);

    state_t state_reg;
    state_t state_next;
    state_t boundary;

    // Instruction boundary: i_run is only honoured here.
    assign boundary = i_run ? ST_T1 : ST_IDLE;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: state_next = boundary;
            ST_T1:   state_next = ST_T2;
            ST_T2:   state_next = ST_T3;
            ST_T3:   state_next = ST_T4;
            ST_T4: begin
                if (i_instr == INS_HLT) begin
                    state_next = ST_HALT;
                end else begin
`ifdef SAP1_CTRL_VAR_LEN_EN
                    if (i_instr == INS_OUT || i_instr == INS_NOP) begin
                        state_next = boundary;
                    end else begin
                        state_next = ST_T5;
                    end
`else
                    state_next = ST_T5;
`endif
                end
            end
            ST_T5: begin
`ifdef SAP1_CTRL_VAR_LEN_EN
                state_next = (i_instr == INS_LDA) ? boundary : ST_T6;
`else
                state_next = ST_T6;
`endif
            end
            ST_T6:   state_next = boundary;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    assign o_state = state_reg;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 control unit: classifies the opcode, runs the T-state sequencer and decodes control lines.
// Build macro SAP1_CTRL_VAR_LEN_EN (handled in sap1_ring_counter) enables variable-length instructions.
module sap1_controller
    import sap1_pkg::*;
#(
    parameter int unsigned OpcodeWidth = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_run,
    input  logic [OpcodeWidth-1:0] i_opcode,
    output logic                   o_cp,
    output logic                   o_ep,
    output logic                   o_lm,
    output logic                   o_er,
    output logic                   o_li,
    output logic                   o_ei,
    output logic                   o_la,
    output logic                   o_ea,
    output logic                   o_su,
    output logic                   o_eu,
    output logic                   o_lb,
    output logic                   o_lo,
    output logic                   o_halted,
    output logic [2:0]             o_tstate
);

    instr_t instr;
    state_t state;

    always_comb begin
        instr = INS_NOP;
        if      (i_opcode == OpcodeWidth'(OP_LDA)) instr = INS_LDA;
        else if (i_opcode == OpcodeWidth'(OP_ADD)) instr = INS_ADD;
        else if (i_opcode == OpcodeWidth'(OP_SUB)) instr = INS_SUB;
        else if (i_opcode == OpcodeWidth'(OP_OUT)) instr = INS_OUT;
        else if (i_opcode == OpcodeWidth'(OP_HLT)) instr = INS_HLT;
    end

    sap1_ring_counter u_ring_counter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_run   (i_run),
        .i_instr (instr),
        .o_state (state)
    );

    // Moore decode; at most one bus driver (ep/er/ei/ea/eu) per state.
    always_comb begin
        o_cp = 1'b0; o_ep = 1'b0; o_lm = 1'b0; o_er = 1'b0;
        o_li = 1'b0; o_ei = 1'b0; o_la = 1'b0; o_ea = 1'b0;
        o_su = 1'b0; o_eu = 1'b0; o_lb = 1'b0; o_lo = 1'b0;
        case (state)
            ST_T1: begin o_ep = 1'b1; o_lm = 1'b1; end
            ST_T2: o_cp = 1'b1;
            ST_T3: begin o_er = 1'b1; o_li = 1'b1; end
            ST_T4: begin
                case (instr)
                    INS_LDA, INS_ADD, INS_SUB: begin o_ei = 1'b1; o_lm = 1'b1; end
                    INS_OUT:                   begin o_ea = 1'b1; o_lo = 1'b1; end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (instr)
                    INS_LDA:          begin o_er = 1'b1; o_la = 1'b1; end
                    INS_ADD, INS_SUB: begin o_er = 1'b1; o_lb = 1'b1; end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (instr)
                    INS_ADD: begin o_eu = 1'b1; o_la = 1'b1; end
                    INS_SUB: begin o_su = 1'b1; o_eu = 1'b1; o_la = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign o_halted = (state == ST_HALT);
    assign o_tstate = state;

endmodule

// File: tb/tb_sap1_controller.sv
// Directed self-checking bench for sap1_controller; follows SAP1_CTRL_VAR_LEN_EN when defined.
module tb_sap1_controller;

    localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, ER = 12'h100;
    localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
    localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;
    localparam logic [11:0] NONE = 12'h000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [3:0] opcode;
    logic       cp, ep, lm, er, li, ei, la, ea, su, eu, lb, lo, halted;
    logic [2:0] tstate;
    logic [11:0] ctrl;

    int n_assert = 0;
    int n_fail   = 0;

    sap1_controller #(.OpcodeWidth(4)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_run    (run),
        .i_opcode (opcode),
        .o_cp     (cp),
        .o_ep     (ep),
        .o_lm     (lm),
        .o_er     (er),
        .o_li     (li),
        .o_ei     (ei),
        .o_la     (la),
        .o_ea     (ea),
        .o_su     (su),
        .o_eu     (eu),
        .o_lb     (lb),
        .o_lo     (lo),
        .o_halted (halted),
        .o_tstate (tstate)
    );

    assign ctrl = {cp, ep, lm, er, li, ei, la, ea, su, eu, lb, lo};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] exp_t, input logic [11:0] exp_c);
        logic exp_h;
        exp_h = (exp_t == 3'd7);
        n_assert++;
        assert (tstate === exp_t) else begin
            n_fail++;
            $error("FAIL %s tstate observed=%0d expected=%0d", tag, tstate, exp_t);
        end
        n_assert++;
        assert (ctrl === exp_c) else begin
            n_fail++;
            $error("FAIL %s ctrl observed=%03h expected=%03h", tag, ctrl, exp_c);
        end
        n_assert++;
        assert (halted === exp_h) else begin
            n_fail++;
            $error("FAIL %s halted observed=%0b expected=%0b", tag, halted, exp_h);
        end
        $display("t=%0t %s tstate=%0d ctrl=%03h halted=%0b", $time, tag, tstate, ctrl, halted);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; opcode = 4'h2;
        #3;
        chk("reset_async", 3'd0, NONE);
        run = 1'b1;
        step(); step();
        chk("reset_held_run", 3'd0, NONE);
        run = 1'b0;
        rst_n = 1'b1;
        step();
        chk("idle_no_run", 3'd0, NONE);

        // SUB, full fetch + execute, loops back to T1
        run = 1'b1;
        step(); chk("sub_t1", 3'd1, EP | LM);
        step(); chk("sub_t2", 3'd2, CP);
        step(); chk("sub_t3", 3'd3, ER | LI);
        step(); chk("sub_t4", 3'd4, EI | LM);
        step(); chk("sub_t5", 3'd5, ER | LB);
        step(); chk("sub_t6", 3'd6, SU | EU | LA);
        step(); chk("sub_next_t1", 3'd1, EP | LM);

        // LDA
        opcode = 4'h0;
        step(); chk("lda_t2", 3'd2, CP);
        step(); chk("lda_t3", 3'd3, ER | LI);
        step(); chk("lda_t4", 3'd4, EI | LM);
        step(); chk("lda_t5", 3'd5, ER | LA);
`ifndef SAP1_CTRL_VAR_LEN_EN
        step(); chk("lda_t6", 3'd6, NONE);
`endif
        step(); chk("lda_next_t1", 3'd1, EP | LM);

        // ADD
        opcode = 4'h1;
        step(); chk("add_t2", 3'd2, CP);
        step(); chk("add_t3", 3'd3, ER | LI);
        step(); chk("add_t4", 3'd4, EI | LM);
        step(); chk("add_t5", 3'd5, ER | LB);
        step(); chk("add_t6", 3'd6, EU | LA);
        step(); chk("add_next_t1", 3'd1, EP | LM);

        // OUT with run dropped in T3: instruction completes, then IDLE
        opcode = 4'hE;
        step(); chk("outstop_t2", 3'd2, CP);
        step(); chk("outstop_t3", 3'd3, ER | LI);
        run = 1'b0;
        step(); chk("outstop_t4", 3'd4, EA | LO);
`ifndef SAP1_CTRL_VAR_LEN_EN
        step(); chk("outstop_t5", 3'd5, NONE);
        step(); chk("outstop_t6", 3'd6, NONE);
`endif
        step(); chk("outstop_idle", 3'd0, NONE);
        step(); chk("outstop_idle2", 3'd0, NONE);
        run = 1'b1;
        step(); chk("restart_t1", 3'd1, EP | LM);

        // OUT with run held
        step(); chk("out_t2", 3'd2, CP);
        step(); chk("out_t3", 3'd3, ER | LI);
        step(); chk("out_t4", 3'd4, EA | LO);
`ifndef SAP1_CTRL_VAR_LEN_EN
        step(); chk("out_t5", 3'd5, NONE);
        step(); chk("out_t6", 3'd6, NONE);
`endif
        step(); chk("out_next_t1", 3'd1, EP | LM);

        // Unknown opcode executes as NOP
        opcode = 4'h5;
        step(); chk("nop_t2", 3'd2, CP);
        step(); chk("nop_t3", 3'd3, ER | LI);
        step(); chk("nop_t4", 3'd4, NONE);
`ifndef SAP1_CTRL_VAR_LEN_EN
        step(); chk("nop_t5", 3'd5, NONE);
        step(); chk("nop_t6", 3'd6, NONE);
`endif
        step(); chk("nop_next_t1", 3'd1, EP | LM);

        // ADD aborted by reset in T5, mid-cycle
        opcode = 4'h1;
        step(); step(); step(); step();
        chk("addrst_t5", 3'd5, ER | LB);
        #2;
        rst_n = 1'b0;
        #1;
        chk("addrst_async", 3'd0, NONE);
        step();
        chk("addrst_held", 3'd0, NONE);
        rst_n = 1'b1;
        step(); chk("addrst_rel_t1", 3'd1, EP | LM);

        // HLT: absorbing regardless of run
        opcode = 4'hF;
        step(); chk("hlt_t2", 3'd2, CP);
        step(); chk("hlt_t3", 3'd3, ER | LI);
        step(); chk("hlt_t4", 3'd4, NONE);
        step(); chk("hlt_enter", 3'd7, NONE);
        for (int i = 0; i < 20; i++) begin
            run = ~run;
            opcode = 4'h1;
            step(); chk($sformatf("hlt_hold%0d", i), 3'd7, NONE);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("hlt_reset", 3'd0, NONE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sap1_controller.md
SAP1_CONTROLLER -- requirements
Module: sap1_controller

Interface
REQ-001 The block SHALL have parameter OpcodeWidth, default 4, giving the instruction opcode width.
REQ-002 Port i_clk SHALL be an input of width 1 and is the single clock; state updates on the rising edge.
REQ-003 Port i_rst_n SHALL be an input of width 1 and is the asynchronous, active-low reset.
REQ-004 Port i_run SHALL be an input of width 1 and is the run enable, sampled only at instruction boundaries.
REQ-005 Port i_opcode SHALL be an input of width OpcodeWidth carrying the instruction register's upper field.
REQ-006 Ports o_cp, o_ep, o_lm, o_er, o_li, o_ei, o_la, o_ea, o_su, o_eu, o_lb and o_lo SHALL be outputs of width 1, each an active-high control line (PC count, PC enable, MAR load, memory read enable, IR load, IR enable, A load, A enable, subtract, ALU enable, B load, output load).
REQ-007 Port o_halted SHALL be an output of width 1, high while in HALT.
REQ-008 Port o_tstate SHALL be an output of width 3 giving the current state encoding.

Function
REQ-009 The states and their o_tstate encodings SHALL be IDLE=0, T1..T6=1..6 and HALT=7.
REQ-010 All control outputs SHALL be a combinational Moore decode of state, plus i_opcode in T4–T6; every line not listed for a state is 0.
REQ-011 The fetch states SHALL decode as: T1: ep, lm; T2: cp; T3: er, li (the IR loads at the end of T3).
REQ-012 LDA (0x0) SHALL decode as: T4: ei, lm; T5: er, la; T6: none.
REQ-013 ADD (0x1) SHALL decode as: T4: ei, lm; T5: er, lb; T6: eu, la.
REQ-014 SUB (0x2) SHALL decode as: T4: ei, lm; T5: er, lb; T6: su, eu, la.
REQ-015 OUT (0xE) SHALL decode as: T4: ea, lo; T5 and T6: none.
REQ-016 For HLT (0xF), T4 SHALL assert no outputs and the next state SHALL be HALT.
REQ-017 Any other opcode SHALL execute as a NOP, with T4–T6 asserting nothing.
REQ-018 Transitions SHALL be: IDLE→T1 if i_run=1, else stay in IDLE; Tn→Tn+1 for n=1..5; T6→T1 if i_run=1, else →IDLE.
REQ-019 HALT SHALL be absorbing, exited only by reset; all control outputs are 0 and o_halted=1.
REQ-020 o_er and o_ei SHALL never be high in the same state, and at most one bus driver (ep, er, ei, ea, eu) SHALL be high in any state.
REQ-021 i_run SHALL have no effect in T1–T5; deasserting it mid-instruction completes the instruction first.

Reset
REQ-022 While i_rst_n=0, the state SHALL be IDLE immediately and asynchronously.
REQ-023 In reset, every control output and o_halted SHALL be 0 and o_tstate=0.
REQ-024 Reset asserted in any state, including mid-instruction or HALT, SHALL abort to IDLE.
REQ-025 After release, the first rising edge with i_run=1 SHALL enter T1.

Configuration
REQ-026 With macro SAP1_CTRL_VAR_LEN_EN defined, the block SHALL skip NOP cycles at boundaries: LDA returns from T5, and OUT and unknown opcodes return from T4, applying the T6 exit rule (i_run=1 →T1, else →IDLE).
REQ-027 Without SAP1_CTRL_VAR_LEN_EN, every instruction other than HLT SHALL take exactly 6 cycles T1–T6.
REQ-028 HLT behaviour SHALL be identical in both builds.

Structure
REQ-029 Package sap1_pkg SHALL hold the opcode constants (LDA, ADD, SUB, OUT, HLT) and the 3-bit state encodings.
REQ-030 Sub-module sap1_ring_counter SHALL hold the state register and next-state logic; sap1_controller instantiates it and contains the output decode.

Verification
REQ-031 Reset then i_run=1 SHALL sequence o_tstate 0→1→2→3→4→5→6→1, with T1 showing ep=lm=1 only and T3 showing er=li=1 only.
REQ-032 i_opcode=0x2 SHALL give T5 er=lb=1 and T6 su=eu=la=1, with all other lines 0.
REQ-033 i_opcode=0xF SHALL give T4 all 0, the next cycle o_tstate=7 and o_halted=1, held for 20 cycles with i_run toggling.
REQ-034 i_run dropped in T3 SHALL still complete T4–T6, then o_tstate=0; raising i_run SHALL enter T1 on the next edge.
REQ-035 With SAP1_CTRL_VAR_LEN_EN and i_opcode=0xE, o_tstate SHALL go 1,2,3,4,1 with ea=lo=1 in T4; without it, it SHALL go 1..6,1.
REQ-036 i_rst_n pulsed low in T5 of ADD SHALL immediately give o_tstate=0 with all outputs 0, asynchronously with respect to i_clk.
